ftdi_245_responder: RTL and testbench

FTDI_245_RESPONDER -- requirements
Module: ftdi_245_responder

---
 rtl/ftdi_245_responder.sv | 152 +++++++++++++++
 tb/tb_ftdi_245_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_245_responder.sv
// Device side of the FTDI async 245 FIFO protocol.
// Two DEPTH-entry byte queues: RQ (host -> FPGA, read via rd_n) and
// WQ (FPGA -> host, written via wr_n), each with a precharge window after a transfer.
// Define FTDI_RESP_ERR_EN to build sticky protocol-error flags on err.
module ftdi_245_responder #(
    parameter int DEPTH     = 8,
    parameter int PRECHARGE = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] adbus_in,
    output logic [7:0] adbus_out,
    output logic       adbus_oe,
    output logic       rxf_n,
    output logic       txe_n,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [2:0] err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PRECHARGE > 1) ? $clog2(PRECHARGE) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [PW-1:0] PRE_LOAD = PW'(PRECHARGE - 1);

    typedef enum logic [1:0] {R_IDLE, R_DRIVE, R_PRE} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_HOLD, W_PRE} wstate_t;

    rstate_t r_state, r_next;
    wstate_t w_state, w_next;
    logic [PW-1:0] r_cnt, w_cnt;

    logic [7:0]    rq_mem [DEPTH];
    logic [AW-1:0] rq_wp, rq_rp;
    logic [AW:0]   rq_cnt;
    logic [7:0]    wq_mem [DEPTH];
    logic [AW-1:0] wq_wp, wq_rp;
    logic [AW:0]   wq_cnt;

    logic rd_q, wr_q;
    logic rd_fall, rd_rise, wr_fall, wr_rise;
    logic rq_push, rq_pop, wq_push, wq_pop;

    assign rd_fall = rd_q & ~rd_n;
    assign rd_rise = ~rd_q & rd_n;
    assign wr_fall = wr_q & ~wr_n;
    assign wr_rise = ~wr_q & wr_n;

    assign host_ready = (rq_cnt != FULL);
    assign rx_valid   = (wq_cnt != '0);
    assign rx_data    = wq_mem[wq_rp];
    assign rq_push    = host_valid & host_ready;
    assign wq_pop     = rx_valid & rx_ready;

    assign rxf_n     = !(r_state == R_IDLE && rq_cnt != '0);
    assign txe_n     = !(w_state == W_IDLE && wq_cnt != FULL);
    assign adbus_oe  = (r_state == R_DRIVE);
    assign adbus_out = adbus_oe ? rq_mem[rq_rp] : '0;

    // Strobe history, FSM state and precharge counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            r_cnt   <= PRE_LOAD;
            w_cnt   <= PRE_LOAD;
        end else begin
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            r_state <= r_next;
            w_state <= w_next;
            r_cnt   <= (r_state != R_PRE) ? PRE_LOAD : ((r_cnt != '0) ? r_cnt - 1'b1 : r_cnt);
            w_cnt   <= (w_state != W_PRE) ? PRE_LOAD : ((w_cnt != '0) ? w_cnt - 1'b1 : w_cnt);
        end
    end

    // Read FSM: drive RQ head while rd_n is low, pop on its rising edge
    always_comb begin
        r_next = r_state;
        rq_pop = 1'b0;
        case (r_state)
            R_IDLE:  if (rd_fall && !rxf_n) r_next = R_DRIVE;
            R_DRIVE: if (rd_rise) begin
                rq_pop = 1'b1;
                r_next = R_PRE;
            end
            R_PRE:   if (r_cnt == '0) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Write FSM: capture on wr_n falling edge; a read in progress takes priority
    always_comb begin
        w_next  = w_state;
        wq_push = 1'b0;
        case (w_state)
            W_IDLE:  if (wr_fall && !txe_n && r_state != R_DRIVE) begin
                wq_push = 1'b1;
                w_next  = W_HOLD;
            end
            W_HOLD:  if (wr_rise) w_next = W_PRE;
            W_PRE:   if (w_cnt == '0) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Queue pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rq_wp  <= '0;
            rq_rp  <= '0;
            rq_cnt <= '0;
            wq_wp  <= '0;
            wq_rp  <= '0;
            wq_cnt <= '0;
        end else begin
            if (rq_push) rq_wp <= rq_wp + 1'b1;
            if (rq_pop)  rq_rp <= rq_rp + 1'b1;
            if (rq_push && !rq_pop)      rq_cnt <= rq_cnt + 1'b1;
            else if (!rq_push && rq_pop) rq_cnt <= rq_cnt - 1'b1;
            if (wq_push) wq_wp <= wq_wp + 1'b1;
            if (wq_pop)  wq_rp <= wq_rp + 1'b1;
            if (wq_push && !wq_pop)      wq_cnt <= wq_cnt + 1'b1;
            else if (!wq_push && wq_pop) wq_cnt <= wq_cnt - 1'b1;
        end
    end

    // Queue storage
    always_ff @(posedge clock) begin
        if (rq_push) rq_mem[rq_wp] <= host_data;
        if (wq_push) wq_mem[wq_wp] <= adbus_in;
    end

`ifdef FTDI_RESP_ERR_EN
    logic [2:0] err_q;
    // Sticky protocol-error flags, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= '0;
        else       err_q <= err_q | {~rd_n & ~wr_n, wr_fall & txe_n, rd_fall & rxf_n};
    end
    assign err = err_q;
`else
    assign err = '0;
`endif
endmodule

// File: tb/tb_ftdi_245_responder.sv
// Directed bench for ftdi_245_responder: table-driven read sequence plus
// hand-written write-fill, empty-read, collision, async-reset and full-queue cases.
module tb_ftdi_245_responder;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] adbus_in = '0, adbus_out;
    logic       adbus_oe, rxf_n, txe_n;
    logic [7:0] host_data = '0;
    logic       host_valid = 1'b0, host_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0;
    logic [2:0] err;

    int n_vec = 0;
    int n_bad = 0;

    ftdi_245_responder #(.DEPTH(8), .PRECHARGE(2)) dut (
        .clock(clock), .reset(reset), .rd_n(rd_n), .wr_n(wr_n),
        .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_oe(adbus_oe),
        .rxf_n(rxf_n), .txe_n(txe_n), .host_data(host_data),
        .host_valid(host_valid), .host_ready(host_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rd_n;
        logic       host_valid;
        logic [7:0] host_data;
        logic       oe;
        logic       rxf;
        logic [7:0] out;
    } vec_t;

    vec_t tbl[16];

`ifdef FTDI_RESP_ERR_EN
    localparam logic [2:0] ERR_EMPTY_RD = 3'b001;
    localparam logic [2:0] ERR_COLLIDE  = 3'b100;
    localparam logic [2:0] ERR_FULL_WR  = 3'b010;
`else
    localparam logic [2:0] ERR_EMPTY_RD = 3'b000;
    localparam logic [2:0] ERR_COLLIDE  = 3'b000;
    localparam logic [2:0] ERR_FULL_WR  = 3'b000;
`endif

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rd_n = 1'b1; wr_n = 1'b1; host_valid = 1'b0; rx_ready = 1'b0; adbus_in = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic push_host(input logic [7:0] d);
        host_valid = 1'b1; host_data = d;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic wr_pulse(input logic [7:0] d);
        wr_n = 1'b0; adbus_in = d;
        tick();
        wr_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic rd_pulse(input string name, input logic [7:0] exp);
        rd_n = 1'b0;
        tick();
        tick();
        check(name, {7'b0, adbus_oe, adbus_out}, {7'b0, 1'b1, exp});
        rd_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        // two bytes pushed, two 4-cycle rd_n pulses, precharge of 2 after each
        //           rd   hv   hdata  oe   rxf  out
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};

        #12;
        check("reset_outputs",
              {2'b0, err, rxf_n, txe_n, adbus_oe, host_ready, rx_valid, adbus_out},
              {2'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
        reset = 1'b0;

        // read sequence table; txe_n stays low and host_ready high throughout
        for (int i = 0; i < 16; i++) begin
            rd_n = tbl[i].rd_n; host_valid = tbl[i].host_valid; host_data = tbl[i].host_data;
            tick();
            check($sformatf("read_vec%0d", i),
                  {4'b0, adbus_oe, rxf_n, host_ready, txe_n, adbus_out},
                  {4'b0, tbl[i].oe, tbl[i].rxf, 1'b1, 1'b0, tbl[i].out});
        end

        // fill WQ with 8 writes, 9th ignored, then drain in order
        do_reset();
        for (int i = 0; i < 8; i++) wr_pulse(8'(i));
        check("wq_full_txe", {15'b0, txe_n}, 16'h0001);
        wr_pulse(8'hEE);
        check("wq_full_err", {13'b0, err}, {13'b0, ERR_FULL_WR});
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wq_pop%0d", i), {7'b0, rx_valid, rx_data}, {7'b0, 1'b1, 8'(i)});
            tick();
        end
        check("wq_drained", {15'b0, rx_valid}, 16'h0000);
        rx_ready = 1'b0;

        // rd_n held low with RQ empty
        do_reset();
        rd_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("empty_rd%0d", i), {14'b0, adbus_oe, rxf_n}, 16'h0001);
        end
        check("empty_rd_err", {13'b0, err}, {13'b0, ERR_EMPTY_RD});
        rd_n = 1'b1;
        tick();

        // wr_n strobe during R_DRIVE is ignored
        do_reset();
        push_host(8'h11);
        rd_n = 1'b0;
        tick();
        tick();
        wr_n = 1'b0; adbus_in = 8'h77;
        tick();
        check("collide_drive", {7'b0, adbus_oe, adbus_out}, {7'b0, 1'b1, 8'h11});
        wr_n = 1'b1;
        tick();
        rd_n = 1'b1;
        tick();
        check("collide_wq", {15'b0, rx_valid}, 16'h0000);
        check("collide_err", {13'b0, err}, {13'b0, ERR_COLLIDE});
        repeat (3) tick();

        // asynchronous reset during a read with three bytes queued
        do_reset();
        push_host(8'h01);
        push_host(8'h02);
        push_host(8'h03);
        rd_n = 1'b0;
        tick();
        tick();
        check("pre_reset_drive", {7'b0, adbus_oe, adbus_out}, {7'b0, 1'b1, 8'h01});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {13'b0, adbus_oe, rxf_n, host_ready}, 16'h0003);
        rd_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("reset_rq_empty", {14'b0, rxf_n, adbus_oe}, 16'h0002);

        // RQ kept full with host_valid high across a completed read
        do_reset();
        host_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_data = 8'h40 + 8'(i);
            tick();
        end
        host_data = 8'h80;
        check("rq_full_ready", {15'b0, host_ready}, 16'h0000);
        rd_n = 1'b0;
        tick();
        tick();
        rd_n = 1'b1;
        tick();
        tick();
        check("rq_refilled", {15'b0, host_ready}, 16'h0000);
        host_valid = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 8; i++) rd_pulse($sformatf("rq_drain%0d", i), 8'h40 + 8'(i));
        rd_pulse("rq_drain_last", 8'h80);
        check("rq_empty_end", {15'b0, rxf_n}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
